// File: rtl/demux_stream.sv
// 1-to-2 stream demultiplexer: each accepted beat lands in the FIFO picked by sel,
// and the two FIFOs drain independently with saturating delivered-beat counters.
module demux_stream #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sel,
  input  logic [WIDTH-1:0] D,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Y0,
  output logic             Y0_valid,
  input  logic             Y0_ready,
  output logic [WIDTH-1:0] Y1,
  output logic             Y1_valid,
  input  logic             Y1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       full;
  logic [1:0]       valid;
  logic [1:0]       ready;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [WIDTH-1:0] head [2];
  logic [CNT_W-1:0] cnt  [2];

  // Acceptance looks only at registered occupancy, never at the consumers.
  assign ready    = {Y1_ready, Y0_ready};
  assign in_ready = en && !full[sel];
  assign push     = (in_valid && in_ready) ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign pop      = valid & ready;

  for (genvar k = 0; k < 2; k++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
        count  <= '0;
      end else begin
        if (push[k])
          wr_ptr <= wr_ptr + 1'b1;
        if (pop[k])
          rd_ptr <= rd_ptr + 1'b1;
        if (push[k] && !pop[k])
          occ <= occ + 1'b1;
        else if (!push[k] && pop[k])
          occ <= occ - 1'b1;
        if (pop[k] && count != CNT_MAX)
          count <= count + 1'b1;
      end
    end

    // Storage is not reset; stale entries are hidden by the valid gating below.
    always_ff @(posedge clk) begin
      if (push[k])
        mem[wr_ptr] <= D;
    end

    assign full[k]  = (occ == FULL_OCC);
    assign valid[k] = (occ != '0);
    assign head[k]  = valid[k] ? mem[rd_ptr] : '0;
    assign cnt[k]   = count;
  end

  assign Y0       = head[0];
  assign Y1       = head[1];
  assign Y0_valid = valid[0];
  assign Y1_valid = valid[1];
  assign cnt0     = cnt[0];
  assign cnt1     = cnt[1];

  a_no_x_on_accept: assert property (@(posedge clk) disable iff (rst)
    (in_valid && in_ready) |-> !$isunknown({sel, D}));

endmodule
